// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for seg7_scan_ctrl.
//   value      : 16-bit hex value, nibble i shown on digit i
//   dp_in      : per-digit decimal-point request, active-high
//   digit_en   : per-digit enable, 0 = digit dark
//   seg        : segments {a..g}, seg[6] = a, active-high
//   dp         : decimal point, active-high
//   line       : digit select, active-low, line[i] selects digit i
//   frame_done : one-cycle pulse at the end of each 4-digit frame
// master = value source / display observer, slave = the scan controller.
interface seg7_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  line;
  logic        frame_done;

  modport master (
    output value, dp_in, digit_en,
    input  seg, dp, line, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en,
    output seg, dp, line, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Each digit gets BLANK_CYC cycles with all lines off followed by CLK_DIV
// cycles of drive. The displayed value, decimal points and enables are
// captured into shadow registers once per frame so a frame never mixes
// two values.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset, blanks outputs immediately
//   bus   : seg7_scan_ctrl_if.slave (value/dp_in/digit_en in,
//           seg/dp/line/frame_done out, all outputs registered)
// Build option: define SEG7_LZ_BLANK_EN to suppress leading zeros on
// digits 3..1 (digit 0 is never suppressed).
module seg7_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned CntMax = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DriveLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]    shadow_val_q, shadow_val_d;
  logic [3:0]     shadow_dp_q, shadow_dp_d;
  logic [3:0]     shadow_en_q, shadow_en_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [3:0]     line_q, line_d;
  logic           frame_done_q, frame_done_d;
  logic           capture;
  logic [3:0]     en_eff;
  logic [3:0]     nibble;

  function automatic logic [6:0] decode(input logic [3:0] n);
    unique case (n)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h72;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      4'hF: decode = 7'h47;
      default: decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CntW'(1);
    frame_done_d = 1'b0;

    // Frame-coherent capture at the very first cycle of digit 0's blank slot.
    capture      = (state_q == StBlank) && (idx_q == 2'd0) && (cnt_q == '0);
    shadow_val_d = capture ? bus.value    : shadow_val_q;
    shadow_dp_d  = capture ? bus.dp_in    : shadow_dp_q;
    shadow_en_d  = capture ? bus.digit_en : shadow_en_q;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StDrive;
          cnt_d   = '0;
        end
      end
      StDrive: begin
        if (cnt_q == DriveLast) begin
          state_d      = StBlank;
          cnt_d        = '0;
          idx_d        = idx_q + 2'd1;
          frame_done_d = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase

`ifdef SEG7_LZ_BLANK_EN
    // Digit i is dark when nibbles i..3 are all zero.
    en_eff = shadow_en_d & {|shadow_val_d[15:12], |shadow_val_d[15:8],
                            |shadow_val_d[15:4], 1'b1};
`else
    en_eff = shadow_en_d;
`endif

    // Outputs follow the next state so they change on the same edge as the FSM;
    // the shadow next-state is used so BLANK_CYC=1 still shows the new capture.
    nibble = shadow_val_d[{idx_d, 2'b00} +: 4];
    seg_d  = 7'h00;
    dp_d   = 1'b0;
    line_d = 4'b1111;
    if ((state_d == StDrive) && en_eff[idx_d]) begin
      seg_d  = decode(nibble);
      dp_d   = shadow_dp_d[idx_d];
      line_d = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      shadow_val_q <= 16'h0000;
      shadow_dp_q  <= 4'h0;
      shadow_en_q  <= 4'h0;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      line_q       <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      line_q       <= line_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.line       = line_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with CLK_DIV=4, BLANK_CYC=2 (24-cycle frame).
// Frame position p counts clock edges from the start of digit 0's blank slot:
// slot = p/6, positions 2..5 of each slot are the drive window.
module tb_seg7_scan_ctrl;
  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned BlankCyc = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if dif ();

  seg7_scan_ctrl #(
    .CLK_DIV  (ClkDiv),
    .BLANK_CYC(BlankCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  int vectors = 0;
  int errors  = 0;

  logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {line, seg, dp, frame_done} after edge p of a frame (p=24 is the
  // first cycle of the next frame, where frame_done pulses).
  function automatic logic [12:0] exp_out(input int p, input logic [3:0] on,
                                          input logic [27:0] segs, input logic [3:0] dps);
    int pos, slot;
    logic [3:0] l;
    logic [6:0] s;
    logic d;
    pos  = p % 24;
    slot = pos / 6;
    l = 4'b1111;
    s = 7'h00;
    d = 1'b0;
    if ((pos % 6) >= 2 && on[slot]) begin
      l = ~(4'b0001 << slot);
      s = segs[slot*7 +: 7];
      d = dps[slot];
    end
    return {l, s, d, (p == 24)};
  endfunction

  function automatic logic [12:0] got_out();
    return {dif.line, dif.seg, dif.dp, dif.frame_done};
  endfunction

  task automatic test_reset();
    logic [12:0] e;
    dif.value    = 16'h1234;
    dif.digit_en = 4'hF;
    dif.dp_in    = 4'h0;
    repeat (3) step();
    vectors++;
    if (got_out() !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", got_out(), {4'b1111, 7'h00, 1'b0, 1'b0});
    end
    #2 rst_n = 1'b1;
    repeat (3) step();
    e = exp_out(3, 4'hF, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0);
    vectors++;
    if (got_out() !== e) begin
      errors++;
      $display("FAIL reset_pre_drive got=%h want=%h", got_out(), e);
    end
    // Assert reset mid-drive, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (got_out() !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", got_out(), {4'b1111, 7'h00, 1'b0, 1'b0});
    end
    repeat (2) step();
    #2 rst_n = 1'b1;
    vectors++;
    if (got_out() !== {4'b1111, 7'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", got_out(), {4'b1111, 7'h00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_scan();
    logic [12:0] e;
    for (int p = 1; p <= 24; p++) begin
      step();
      e = exp_out(p, 4'hF, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0);
      vectors++;
      if (got_out() !== e) begin
        errors++;
        $display("FAIL scan p=%0d got=%h want=%h", p, got_out(), e);
      end
    end
  endtask

  task automatic test_coherence();
    logic [12:0] e;
    for (int p = 1; p <= 24; p++) begin
      step();
      e = exp_out(p, 4'hF, {7'h30, 7'h6D, 7'h79, 7'h33}, 4'h0);
      vectors++;
      if (got_out() !== e) begin
        errors++;
        $display("FAIL coherent_old p=%0d got=%h want=%h", p, got_out(), e);
      end
      if (p == 9) dif.value = 16'hABCD;
    end
    for (int p = 1; p <= 24; p++) begin
      step();
      e = exp_out(p, 4'hF, {7'h77, 7'h1F, 7'h4E, 7'h3D}, 4'h0);
      vectors++;
      if (got_out() !== e) begin
        errors++;
        $display("FAIL coherent_new p=%0d got=%h want=%h", p, got_out(), e);
      end
    end
  endtask

  task automatic test_enable_dp();
    logic [12:0] e;
    dif.value    = 16'h8888;
    dif.digit_en = 4'b0101;
    dif.dp_in    = 4'b0100;
    for (int p = 1; p <= 24; p++) begin
      step();
      e = exp_out(p, 4'b0101, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b0100);
      vectors++;
      if (got_out() !== e) begin
        errors++;
        $display("FAIL enable_dp p=%0d got=%h want=%h", p, got_out(), e);
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [12:0] e;
    dif.digit_en = 4'b0001;
    dif.dp_in    = 4'h0;
    for (int n = 0; n < 16; n++) begin
      dif.value = 16'(n);
      for (int p = 1; p <= 24; p++) begin
        step();
        e = exp_out(p, 4'b0001, {21'h0, dec_tab[n]}, 4'h0);
        vectors++;
        if (got_out() !== e) begin
          errors++;
          $display("FAIL decode n=%h p=%0d got=%h want=%h", n, p, got_out(), e);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [12:0] e;
    logic [3:0] on;
`ifdef SEG7_LZ_BLANK_EN
    on = 4'b0011;
`else
    on = 4'b1111;
`endif
    dif.value    = 16'h0050;
    dif.digit_en = 4'hF;
    dif.dp_in    = 4'h0;
    for (int p = 1; p <= 24; p++) begin
      step();
      e = exp_out(p, on, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'h0);
      vectors++;
      if (got_out() !== e) begin
        errors++;
        $display("FAIL lead_zero p=%0d got=%h want=%h", p, got_out(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherence();
    test_enable_dp();
    test_decode_sweep();
    test_lz();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
